bus_ctrl: RTL

BUS_CTRL -- requirements
Module: bus_ctrl

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_if.sv | 44 ++++
 rtl/bus_addr_dec.sv | 21 ++
 rtl/bus_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared encodings and address map for the two-master / two-slave bus controller.
package bus_pkg;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    S0   = 2'd1,
    S1   = 2'd2
  } rsel_t;

  localparam int S0_BASE  = 'h00;
  localparam int S1_BASE  = 'h20;
  localparam int SLV_SIZE = 'h20;

  // Unsigned window test; the subtraction wraps so addresses below base fall outside.
  function automatic logic in_window(input logic [31:0] addr, input int base);
    logic [31:0] off;
    off = addr - 32'(base);
    return off < 32'(SLV_SIZE);
  endfunction

endpackage

// File: rtl/bus_if.sv
// Master-side and slave-side signals of the shared bus, grouped for the controller port.
interface bus_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              M0_req;
  logic              M1_req;
  logic              M0_wr;
  logic              M1_wr;
  logic [ADDR_W-1:0] M0_addr;
  logic [ADDR_W-1:0] M1_addr;
  logic [DATA_W-1:0] M0_dout;
  logic [DATA_W-1:0] M1_dout;
  logic              M0_grant;
  logic              M1_grant;
  logic [DATA_W-1:0] M_din;
  logic              M_err;

  logic              S0_sel;
  logic              S1_sel;
  logic              S_wr;
  logic [ADDR_W-1:0] S_addr;
  logic [DATA_W-1:0] S_din;
  logic [DATA_W-1:0] S0_dout;
  logic [DATA_W-1:0] S1_dout;

  // Controller view: requests and slave read data in, grants and slave strobes out.
  modport slave (
    input  M0_req, M1_req, M0_wr, M1_wr, M0_addr, M1_addr, M0_dout, M1_dout,
    input  S0_dout, S1_dout,
    output M0_grant, M1_grant, M_din, M_err,
    output S0_sel, S1_sel, S_wr, S_addr, S_din
  );

  // Environment view: the masters and slave memories that surround the controller.
  modport master (
    output M0_req, M1_req, M0_wr, M1_wr, M0_addr, M1_addr, M0_dout, M1_dout,
    output S0_dout, S1_dout,
    input  M0_grant, M1_grant, M_din, M_err,
    input  S0_sel, S1_sel, S_wr, S_addr, S_din
  );

endinterface

// File: rtl/bus_addr_dec.sv
// Address decoder: classifies an address as slave 0, slave 1 or unmapped.
// Purely combinational, no backpressure.
module bus_addr_dec
  import bus_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit_s0,
  output logic              hit_s1,
  output logic              unmapped
);

  logic [31:0] addr_ext;

  assign addr_ext = 32'(addr);
  assign hit_s0   = in_window(addr_ext, S0_BASE);
  assign hit_s1   = in_window(addr_ext, S1_BASE);
  assign unmapped = !hit_s0 && !hit_s1;

endmodule

// File: rtl/bus_ctrl.sv
// Two-master bus arbiter and router; selects are combinational, read data and error return one cycle later.
// No backpressure: the granted master may issue a transfer every cycle; the other master simply waits for grant.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic  clk,
  input  logic  reset_n,
  bus_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;
  rsel_t             rsel;
  rsel_t             rsel_nxt;
  logic              err_q;
  logic              err_nxt;

  logic              g_req;
  logic              g_wr;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_dout;

  logic              hit_s0;
  logic              hit_s1;
  logic              unmapped;
  logic [DATA_W-1:0] m_din;

  // M0 has priority in GNT_M0; M1 is never preempted once it holds the bus.
  always_comb begin
    state_nxt = state;
    case (state)
      GNT_M0: if (!bus.M0_req && bus.M1_req) state_nxt = GNT_M1;
      GNT_M1: if (!bus.M1_req) state_nxt = GNT_M0;
      default: state_nxt = GNT_M0;
    endcase
  end

  always_comb begin
    g_req  = bus.M0_req;
    g_wr   = bus.M0_wr;
    g_addr = bus.M0_addr;
    g_dout = bus.M0_dout;
    if (state == GNT_M1) begin
      g_req  = bus.M1_req;
      g_wr   = bus.M1_wr;
      g_addr = bus.M1_addr;
      g_dout = bus.M1_dout;
    end
  end

  bus_addr_dec #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr     (g_addr),
    .hit_s0   (hit_s0),
    .hit_s1   (hit_s1),
    .unmapped (unmapped)
  );

  always_comb begin
    rsel_nxt = NONE;
    if (g_req && !g_wr) begin
      if (hit_s0)      rsel_nxt = S0;
      else if (hit_s1) rsel_nxt = S1;
    end
    err_nxt = g_req && unmapped;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= GNT_M0;
      rsel  <= NONE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rsel  <= rsel_nxt;
      err_q <= err_nxt;
    end
  end

  // rsel remembers which slave owes data, so a grant change cannot redirect it.
  always_comb begin
    m_din = '0;
    case (rsel)
      S0:      m_din = bus.S0_dout;
      S1:      m_din = bus.S1_dout;
      default: m_din = '0;
    endcase
  end

  assign bus.M0_grant = (state == GNT_M0);
  assign bus.M1_grant = (state == GNT_M1);
  assign bus.M_din    = m_din;
  assign bus.M_err    = err_q;

  assign bus.S0_sel   = g_req && hit_s0;
  assign bus.S1_sel   = g_req && hit_s1;
  assign bus.S_wr     = g_wr;
  assign bus.S_addr   = g_addr;
  assign bus.S_din    = g_dout;

endmodule
